// File: rtl/pipe_pkg.sv
// Shared opcodes and packet type for the ADD/SUB pipeline and its issue queue.
package pipe_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_NOP = 4'hF;

   localparam int DEF_DATA_W = 32;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] instruction;
      logic [DEF_DATA_W-1:0] operand1;
      logic [DEF_DATA_W-1:0] operand2;
   } issue_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and an occupancy count that alone decides full/empty.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 96
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset: entries are only observable once count covers them.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_issue_queue.sv
// Issue queue feeding the ADD/SUB pipeline: one packet or NOP bubble per enabled cycle.
// Optional saturating statistics outputs are enabled with `define ISSUE_STATS_EN.
module instr_issue_queue
   import pipe_pkg::*;
#(
   parameter int         DEPTH      = 8,
   parameter int         DATA_W     = DEF_DATA_W,
   parameter logic [3:0] NOP_OPCODE = OP_NOP
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_instruction,
   input  logic [DATA_W-1:0]        in_operand1,
   input  logic [DATA_W-1:0]        in_operand2,
   input  logic                     issue_en,
   input  logic                     flush,
   output logic [DATA_W-1:0]        instruction,
   output logic [DATA_W-1:0]        operand1,
   output logic [DATA_W-1:0]        operand2,
   output logic                     issue_valid,
   output logic [15:0]              issue_pc,
`ifdef ISSUE_STATS_EN
   output logic [31:0]              stat_issued,
   output logic [31:0]              stat_bubbles,
   output logic [31:0]              stat_stall_in,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = 3 * DATA_W;
   localparam logic [DATA_W-1:0] NOP_INSTR = {NOP_OPCODE, {(DATA_W-4){1'b0}}};

   logic [PW-1:0] head;
   logic          full;
   logic          empty;
   logic          do_pop;
   logic          do_bubble;
   logic [15:0]   next_pc;

   assign in_ready  = !full;
   // Pop decision sees count before any same-cycle push, so there is no bypass path.
   assign do_pop    = issue_en && !empty && !flush;
   assign do_bubble = flush || (issue_en && empty);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (in_valid),
      .pop     (issue_en),
      .flush   (flush),
      .wr_data ({in_instruction, in_operand1, in_operand2}),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Output stage: issue, bubble or hold; issue_pc shows the number of the packet on the outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= NOP_INSTR;
         operand1    <= '0;
         operand2    <= '0;
         issue_valid <= 1'b0;
         issue_pc    <= '0;
         next_pc     <= '0;
      end else if (do_bubble) begin
         instruction <= NOP_INSTR;
         operand1    <= '0;
         operand2    <= '0;
         issue_valid <= 1'b0;
      end else if (do_pop) begin
         instruction <= head[PW-1 -: DATA_W];
         operand1    <= head[2*DATA_W-1 -: DATA_W];
         operand2    <= head[DATA_W-1:0];
         issue_valid <= 1'b1;
         issue_pc    <= next_pc;
         next_pc     <= next_pc + 16'd1;
      end
   end

`ifdef ISSUE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_issued   <= '0;
         stat_bubbles  <= '0;
         stat_stall_in <= '0;
      end else begin
         if (do_pop && stat_issued != '1)
            stat_issued <= stat_issued + 32'd1;
         if (do_bubble && stat_bubbles != '1)
            stat_bubbles <= stat_bubbles + 32'd1;
         if (in_valid && !in_ready && stat_stall_in != '1)
            stat_stall_in <= stat_stall_in + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue (default DEPTH=8, DATA_W=32).
module tb_instr_issue_queue;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instruction;
   logic [31:0] in_operand1;
   logic [31:0] in_operand2;
   logic        issue_en;
   logic        flush;
   logic [31:0] instruction;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        issue_valid;
   logic [15:0] issue_pc;
   logic [3:0]  count;
`ifdef ISSUE_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_bubbles;
   logic [31:0] stat_stall_in;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP_I = 32'hF000_0000;

   instr_issue_queue dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instruction (in_instruction),
      .in_operand1    (in_operand1),
      .in_operand2    (in_operand2),
      .issue_en       (issue_en),
      .flush          (flush),
      .instruction    (instruction),
      .operand1       (operand1),
      .operand2       (operand2),
      .issue_valid    (issue_valid),
      .issue_pc       (issue_pc),
`ifdef ISSUE_STATS_EN
      .stat_issued    (stat_issued),
      .stat_bubbles   (stat_bubbles),
      .stat_stall_in  (stat_stall_in),
`endif
      .count          (count)
   );

   always #5 clk = ~clk;

   function automatic issue_pkt_t mk_pkt(input int i);
      issue_pkt_t p;
      p.instruction = 32'h0000_0100 + 32'(i);
      p.operand1    = 32'd100 + 32'(i);
      p.operand2    = 32'(i);
      return p;
   endfunction

   function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      if (ins[31:28] == OP_ADD) return a + b;
      if (ins[31:28] == OP_SUB) return a - b;
      return 32'd0;
   endfunction

   task automatic drive(input logic v, input issue_pkt_t p);
      in_valid       = v;
      in_instruction = p.instruction;
      in_operand1    = p.operand1;
      in_operand2    = p.operand2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; issue_en = 1'b1;
      drive(1'b0, mk_pkt(0));
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {NOP_I, 32'd0, 32'd0, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL reset_outputs got %h/%h/%h v%b pc%0d", instruction, operand1, operand2, issue_valid, issue_pc);
      end
      checks++;
      if ({in_ready, count} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL reset_ctrl got ready=%b count=%0d want ready=1 count=0", in_ready, count);
      end
`ifdef ISSUE_STATS_EN
      checks++;
      if (stat_issued !== 32'd0) begin
         errors++;
         $display("FAIL reset_stat_issued got %0d want 0", stat_issued);
      end
`endif
   endtask

   task automatic test_back_to_back();
      issue_pkt_t a, b;
      a.instruction = 32'h0000_0000; a.operand1 = 32'd5; a.operand2 = 32'd3;
      b.instruction = 32'h1000_0000; b.operand1 = 32'd9; b.operand2 = 32'd4;
      issue_en = 1'b1;
      drive(1'b1, a);
      tick();
      checks++;
      if (issue_valid !== 1'b0 || count !== 4'd1) begin
         errors++;
         $display("FAIL b2b_first_edge got v=%b count=%0d want v=0 count=1", issue_valid, count);
      end
      drive(1'b1, b);
      tick();
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {a, 1'b1, 16'd0}) begin
         errors++;
         $display("FAIL b2b_pkt_a got %h/%h/%h v%b pc%0d", instruction, operand1, operand2, issue_valid, issue_pc);
      end
      checks++;
      if (alu(instruction, operand1, operand2) !== 32'd8) begin
         errors++;
         $display("FAIL b2b_result_a got %0d want 8", alu(instruction, operand1, operand2));
      end
      drive(1'b0, b);
      tick();
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc, count} !== {b, 1'b1, 16'd1, 4'd0}) begin
         errors++;
         $display("FAIL b2b_pkt_b got %h/%h/%h v%b pc%0d count%0d", instruction, operand1, operand2, issue_valid, issue_pc, count);
      end
      checks++;
      if (alu(instruction, operand1, operand2) !== 32'd5) begin
         errors++;
         $display("FAIL b2b_result_b got %0d want 5", alu(instruction, operand1, operand2));
      end
      tick();
      checks++;
      if ({instruction, issue_valid, issue_pc} !== {NOP_I, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL b2b_bubble got %h v%b pc%0d want %h v0 pc1", instruction, issue_valid, issue_pc, NOP_I);
      end
   endtask

   task automatic test_fill();
      issue_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready_%0d got %b want 1", i, in_ready);
         end
         drive(1'b1, mk_pkt(i));
         tick();
         checks++;
         if (count !== 4'(i + 1)) begin
            errors++;
            $display("FAIL fill_count_%0d got %0d want %0d", i, count, i + 1);
         end
      end
      drive(1'b1, mk_pkt(8));
      tick();
      checks++;
      if ({in_ready, count} !== {1'b0, 4'd8}) begin
         errors++;
         $display("FAIL full_hold got ready=%b count=%0d want ready=0 count=8", in_ready, count);
      end
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {NOP_I, 32'd0, 32'd0, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL full_outputs_held got %h/%h/%h v%b pc%0d", instruction, operand1, operand2, issue_valid, issue_pc);
      end
   endtask

   task automatic test_wrap_stream();
      int nxt = 8;
      logic acc;
      issue_en = 1'b1;
      for (int c = 0; c < 15; c++) begin
         drive(c < 12, mk_pkt(nxt));
         acc = in_valid && in_ready;
         tick();
         if (acc) nxt++;
         checks++;
         if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {mk_pkt(c), 1'b1, 16'(c + 2)}) begin
            errors++;
            $display("FAIL wrap_order_%0d got %h/%h/%h v%b pc%0d want %h pc%0d", c, instruction, operand1, operand2, issue_valid, issue_pc, mk_pkt(c).instruction, c + 2);
         end
         checks++;
         if (count !== ((c < 12) ? 4'd7 : 4'(18 - c))) begin
            errors++;
            $display("FAIL wrap_count_%0d got %0d want %0d", c, count, (c < 12) ? 7 : 18 - c);
         end
      end
   endtask

   task automatic test_flush();
      flush = 1'b1; issue_en = 1'b1;
      drive(1'b1, mk_pkt(50));
      tick();
      flush = 1'b0;
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc, count} !== {NOP_I, 32'd0, 32'd0, 1'b0, 16'd16, 4'd0}) begin
         errors++;
         $display("FAIL flush_state got %h v%b pc%0d count%0d want bubble pc16 count0", instruction, issue_valid, issue_pc, count);
      end
      drive(1'b1, mk_pkt(51));
      tick();
      drive(1'b0, mk_pkt(51));
      tick();
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {mk_pkt(51), 1'b1, 16'd17}) begin
         errors++;
         $display("FAIL flush_next_issue got %h v%b pc%0d want %h pc17", instruction, issue_valid, issue_pc, mk_pkt(51).instruction);
      end
   endtask

   task automatic test_reset_mid();
      issue_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, mk_pkt(60 + i));
         tick();
      end
      drive(1'b0, mk_pkt(0));
      checks++;
      if (count !== 4'd5 || issue_pc !== 16'd17) begin
         errors++;
         $display("FAIL mid_prefill got count=%0d pc=%0d want 5 17", count, issue_pc);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc, count, in_ready} !== {NOP_I, 32'd0, 32'd0, 1'b0, 16'd0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_async got %h v%b pc%0d count%0d ready%b", instruction, issue_valid, issue_pc, count, in_ready);
      end
      reset = 1'b0;
      issue_en = 1'b1;
      drive(1'b1, mk_pkt(70));
      tick();
      drive(1'b0, mk_pkt(70));
      tick();
      checks++;
      if ({instruction, operand1, operand2, issue_valid, issue_pc} !== {mk_pkt(70), 1'b1, 16'd0}) begin
         errors++;
         $display("FAIL mid_reset_reissue got %h v%b pc%0d want %h pc0", instruction, issue_valid, issue_pc, mk_pkt(70).instruction);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_fill();
      test_wrap_stream();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Upstream issue stage for the two-stage ADD/SUB pipeline.
- Buffers instruction packets {instruction, operand1, operand2} from a loader or testbench through a valid/ready handshake.
- Drives exactly one packet per enabled cycle onto the pipeline's instruction/operand1/operand2 inputs.
- Substitutes a NOP bubble when no packet is available.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DATA_W, 32, width of instruction and each operand.
- NOP_OPCODE, 4'hF, opcode placed in instruction[31:28] of bubbles; must not be 4'h0 (ADD) or 4'h1 (SUB).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  loader presents a packet.
- in_ready  output  1  queue can accept; equals !full, combinational from count.
- in_instruction  input  DATA_W  packet instruction.
- in_operand1  input  DATA_W  packet operand 1.
- in_operand2  input  DATA_W  packet operand 2.
- issue_en  input  1  pipeline advances this cycle; low = hold outputs.
- flush  input  1  synchronous discard of all queued packets.
- instruction  output  DATA_W  to pipeline, registered.
- operand1  output  DATA_W  to pipeline, registered.
- operand2  output  DATA_W  to pipeline, registered.
- issue_valid  output  1  1 = real packet on outputs, 0 = bubble.
- issue_pc  output  16  sequence number of the issued real packet; increments per real issue, wraps 16'hFFFF -> 0.
- count  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset, asynchronous:
  - count=0, wr/rd pointers=0, issue_pc=0, issue_valid=0.
  - instruction={NOP_OPCODE,28'h0}; operand1=0, operand2=0.
  - in_ready=1 once reset deasserts.
- Push: on a rising edge with in_valid && in_ready, the packet is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: on a rising edge with issue_en && count!=0 && !flush:
  - The head entry is loaded into the output registers.
  - issue_valid=1; issue_pc increments after the issue. The first real packet carries issue_pc=0.
  - rd_ptr increments modulo DEPTH.
- Bubble: on a rising edge with issue_en && count==0:
  - Outputs load {NOP_OPCODE,28'h0}, 0, 0; issue_valid=0.
  - issue_pc is unchanged.
- Hold: when issue_en=0, outputs, issue_valid and issue_pc keep their values; no pop occurs.
- Pop decisions use count before the same-cycle push; there is no bypass.
  - Minimum latency from accepted push to outputs is 2 edges when the queue is empty.
- Simultaneous push and pop: count is unchanged, both pointers advance. This is legal at any count except full, where in_ready=0 so no push occurs.
- Full (count==DEPTH): in_ready=0; in_valid is ignored; the loader must hold its packet.
- Empty: bubbles issue every enabled cycle; the pipeline computes 0 for NOP_OPCODE.
- Flush has priority over push and pop in the same cycle:
  - Pointers=0, count=0.
  - Outputs load a bubble regardless of issue_en.
  - issue_pc is retained.
- Pointer wrap: pointers carry log2(DEPTH) bits and wrap silently. Full/empty are decided by count, not by pointer compare.
- Reset asserted mid-operation discards all contents immediately, with no drain.
- State view, derived from count: EMPTY(0) -> PARTIAL on push; PARTIAL -> FULL on push at DEPTH-1 without pop; FULL -> PARTIAL on pop; PARTIAL -> EMPTY on pop at 1 without push; any -> EMPTY on flush.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_issued[31:0] (real issues) and stat_bubbles[31:0] (bubbles, including flush-cycle bubbles), plus stat_stall_in[31:0] (cycles with in_valid && !in_ready).
  - All are saturating, reset to 0, and not cleared by flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - Opcode constants OP_ADD=4'h0, OP_SUB=4'h1, OP_NOP=4'hF.
  - DATA_W default.
  - Packed typedef issue_pkt_t {instruction, operand1, operand2}.
- One sub-module, sync_fifo: storage, pointers, count, full/empty, parameterised by width and DEPTH.
- The issue/bubble/hold/flush output register logic stays in instr_issue_queue.

Test Plan:
- Reset with in_valid=0, issue_en=1 for 3 cycles -> instruction=32'hF0000000, issue_valid=0, in_ready=1, count=0.
- Push {32'h00000000,5,3} then {32'h10000000,9,4} on back-to-back cycles, issue_en=1 -> the first appears 2 edges after its push with issue_pc=0, the second the next cycle with issue_pc=1; downstream results are 8 then 5.
- Push 9 packets with issue_en=0 -> count saturates at 8; in_ready=0 from the 8th accept; the 9th is held by the loader; outputs are unchanged.
- Full queue, then issue_en=1 with in_valid=1 continuously -> one pop and one push per cycle after the first pop; count stays at 7 or 8; packets issue in exact push order across pointer wrap.
- Queue holding 4 entries, flush=1 with in_valid=1 and issue_en=1 -> count=0, bubble issued, push dropped, issue_pc unchanged; the next push issues normally.
- Assert reset mid-stream with count=5 -> all outputs reach reset values before the next edge; the next packet issues with issue_pc=0.
